// File: rtl/alu_pkg.sv
// Shared opcode, state and flag-index definitions for the sequential ALU.
package alu_pkg;

  typedef enum logic [3:0] {
    ADD = 4'd0,
    SUB = 4'd1,
    MUL = 4'd2,
    DIV = 4'd3,
    MOD = 4'd4,
    AND = 4'd5,
    OR  = 4'd6,
    XOR = 4'd7,
    SHR = 4'd8,
    SHL = 4'd9
  } alu_op_e;

  localparam int FLG_V  = 0;
  localparam int FLG_C  = 1;
  localparam int FLG_Z  = 2;
  localparam int FLG_N  = 3;
  localparam int FLG_DZ = 4;
  localparam int FLG_W  = 5;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    DIVIDE,
    DONE
  } state_e;

endpackage

// File: rtl/alu_div_iter.sv
// Iterative restoring divider: one quotient bit per cycle, N cycles after start.
module alu_div_iter #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] quot,
  output logic [N-1:0] rem
);

  localparam int CNT_W = $clog2(N + 1);

  logic [CNT_W-1:0] cnt_q;
  logic [N-1:0]     quot_q;
  logic [N-1:0]     rem_q;
  logic [N-1:0]     dvs_q;
  logic             done_q;

  logic [N:0]       shifted;
  logic             ge;
  logic [N-1:0]     step_rem;
  logic [N-1:0]     step_quot;

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  // When the subtraction is taken the true difference is below the divisor,
  // so the low N bits of the modular difference are exact.
  always_comb begin
    shifted   = {rem_q, quot_q[N-1]};
    ge        = (shifted >= {1'b0, dvs_q});
    step_rem  = ge ? (shifted[N-1:0] - dvs_q) : shifted[N-1:0];
    step_quot = {quot_q[N-2:0], ge};
  end

  // Load on start, then iterate while the down-counter is non-zero; done pulses
  // for one cycle after the last step and quot/rem hold until the next start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      quot_q <= '0;
      rem_q  <= '0;
      dvs_q  <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start) begin
        cnt_q  <= CNT_W'(N);
        quot_q <= a;
        rem_q  <= '0;
        dvs_q  <= b;
      end else if (cnt_q != '0) begin
        cnt_q  <= cnt_q - CNT_W'(1);
        quot_q <= step_quot;
        rem_q  <= step_rem;
        if (cnt_q == CNT_W'(1)) begin
          done_q <= 1'b1;
        end
      end
    end
  end

  assign busy = (cnt_q != '0);
  assign done = done_q;
  assign quot = quot_q;
  assign rem  = rem_q;

endmodule

// File: rtl/alu_seq_unit.sv
// Registered ALU with valid/ready on both sides; DIV/MOD use the iterative divider.
//
// state  | meaning
// IDLE   | ready for a new transaction (in_ready=1)
// EXEC   | single-cycle op (or divide-by-zero) computing from latched operands
// DIVIDE | waiting for the iterative divider to finish
// DONE   | result/flags valid, held until out_ready
module alu_seq_unit
  import alu_pkg::*;
#(
  parameter int N = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [N-1:0]     a,
  input  logic [N-1:0]     b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     result,
  output logic [FLG_W-1:0] flags
);

  state_e state_q, state_d;

  logic [3:0]       op_q;
  logic [N-1:0]     a_q;
  logic [N-1:0]     b_q;

  logic             accept;
  logic             is_div_in;
  logic             div_start;
  logic             div_busy;
  logic             div_done;
  logic             div_finish;
  logic [N-1:0]     div_quot;
  logic [N-1:0]     div_rem;

  logic [N:0]       sum;
  logic [N:0]       diff;
  logic [2*N-1:0]   prod;
  logic [N-1:0]     exec_res;
  logic             exec_c;
  logic             exec_v;
  logic             exec_dz;
  logic             exec_legal;
  logic [FLG_W-1:0] exec_flg;
  logic [N-1:0]     div_res;
  logic [FLG_W-1:0] div_flg;

  // accept is derived from the state register directly so the handshake
  // outputs never feed back into the next-state logic.
  assign accept     = in_valid && (state_q == IDLE);
  assign is_div_in  = (alu_op_e'(op) == DIV) || (alu_op_e'(op) == MOD);
  assign div_start  = accept && is_div_in && (b != '0);
  assign div_finish = div_done && !div_busy;

  alu_div_iter #(.N(N)) u_div (
    .clk   (clk),
    .rst_n (rst_n),
    .start (div_start),
    .a     (a),
    .b     (b),
    .busy  (div_busy),
    .done  (div_done),
    .quot  (div_quot),
    .rem   (div_rem)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and handshake outputs; a zero divisor takes the EXEC path.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_d = div_start ? DIVIDE : EXEC;
        end
      end
      EXEC: begin
        state_d = DONE;
      end
      DIVIDE: begin
        if (div_finish) begin
          state_d = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Operand capture on accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q <= '0;
      a_q  <= '0;
      b_q  <= '0;
    end else if (accept) begin
      op_q <= op;
      a_q  <= a;
      b_q  <= b;
    end
  end

  // Single-cycle datapath; DIV/MOD only reach here with a zero divisor.
  // Shifts by b >= N naturally yield zero for an N-bit logical shift.
  always_comb begin
    sum        = {1'b0, a_q} + {1'b0, b_q};
    diff       = {1'b0, a_q} - {1'b0, b_q};
    prod       = {{N{1'b0}}, a_q} * {{N{1'b0}}, b_q};
    exec_res   = '0;
    exec_c     = 1'b0;
    exec_v     = 1'b0;
    exec_dz    = 1'b0;
    exec_legal = 1'b1;
    case (alu_op_e'(op_q))
      ADD: begin
        exec_res = sum[N-1:0];
        exec_c   = sum[N];
        exec_v   = (a_q[N-1] == b_q[N-1]) && (exec_res[N-1] != a_q[N-1]);
      end
      SUB: begin
        exec_res = diff[N-1:0];
        exec_c   = diff[N];
        exec_v   = (a_q[N-1] != b_q[N-1]) && (exec_res[N-1] != a_q[N-1]);
      end
      MUL: begin
        exec_res = prod[N-1:0];
        exec_c   = |prod[2*N-1:N];
      end
      DIV: begin
        exec_res = '1;
        exec_dz  = 1'b1;
      end
      MOD: begin
        exec_res = a_q;
        exec_dz  = 1'b1;
      end
      AND:     exec_res = a_q & b_q;
      OR:      exec_res = a_q | b_q;
      XOR:     exec_res = a_q ^ b_q;
      SHR:     exec_res = a_q >> b_q;
      SHL:     exec_res = a_q << b_q;
      default: exec_legal = 1'b0;
    endcase
    exec_flg = '0;
    if (exec_legal) begin
      exec_flg[FLG_DZ] = exec_dz;
      exec_flg[FLG_N]  = exec_res[N-1];
      exec_flg[FLG_Z]  = (exec_res == '0);
      exec_flg[FLG_C]  = exec_c;
      exec_flg[FLG_V]  = exec_v;
    end
  end

  // Divider result selection and its flags (C, V and DZ are always zero here).
  always_comb begin
    div_res        = (alu_op_e'(op_q) == MOD) ? div_rem : div_quot;
    div_flg        = '0;
    div_flg[FLG_N] = div_res[N-1];
    div_flg[FLG_Z] = (div_res == '0);
  end

  // Output registers load when leaving EXEC or DIVIDE and hold through DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result <= '0;
      flags  <= '0;
    end else if (state_q == EXEC) begin
      result <= exec_res;
      flags  <= exec_flg;
    end else if ((state_q == DIVIDE) && div_finish) begin
      result <= div_res;
      flags  <= div_flg;
    end
  end

endmodule

// File: tb/tb_alu_seq_unit.sv
// Randomised and directed bench for alu_seq_unit (N=4) against a behavioural model.
module tb_alu_seq_unit;

  localparam int N    = 4;
  localparam int M    = (1 << N) - 1;
  localparam int SMAX = (1 << (N - 1)) - 1;
  localparam int SMIN = -(1 << (N - 1));

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [3:0]   op = '0;
  logic [N-1:0] a = '0;
  logic [N-1:0] b = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [N-1:0] result;
  logic [4:0]   flags;

  int total = 0;
  int bad   = 0;

  int exp_res, exp_flg, exp_lat;
  int seen_res, seen_flg;
  int edges = 0;
  bit armed = 0;
  bit track = 0;
  bit prev_ov = 0;

  alu_seq_unit #(.N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flags     (flags)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string name, input int act, input int expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  function automatic int sgn(input int x);
    return (x > SMAX) ? x - (1 << N) : x;
  endfunction

  // Expected result, flags {DZ,N,Z,C,V} and latency (accept cycle counted as cycle 1).
  function automatic void model(input int o, input int ia, input int ib,
                                output int r, output int f, output int lat);
    int c, v, dz, s;
    bit legal;
    c = 0; v = 0; dz = 0; legal = 1; r = 0; lat = 2;
    case (o)
      0: begin
        s = ia + ib; r = s & M; c = (s > M) ? 1 : 0;
        s = sgn(ia) + sgn(ib); v = (s > SMAX || s < SMIN) ? 1 : 0;
      end
      1: begin
        r = (ia - ib) & M; c = (ia < ib) ? 1 : 0;
        s = sgn(ia) - sgn(ib); v = (s > SMAX || s < SMIN) ? 1 : 0;
      end
      2: begin
        s = ia * ib; r = s & M; c = (s > M) ? 1 : 0;
      end
      3: if (ib == 0) begin r = M; dz = 1; end
         else begin r = ia / ib; lat = N + 2; end
      4: if (ib == 0) begin r = ia; dz = 1; end
         else begin r = ia % ib; lat = N + 2; end
      5: r = ia & ib;
      6: r = ia | ib;
      7: r = ia ^ ib;
      8: r = (ib >= N) ? 0 : (ia >> ib);
      9: r = (ib >= N) ? 0 : ((ia << ib) & M);
      default: legal = 0;
    endcase
    if (legal)
      f = (dz ? 16 : 0) + ((r > SMAX) ? 8 : 0) + ((r == 0) ? 4 : 0) + (c ? 2 : 0) + (v ? 1 : 0);
    else
      f = 0;
  endfunction

  // Per-cycle compare against the model for the outstanding transaction.
  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      track   = 0;
      armed   = 0;
      prev_ov = 0;
    end else begin
      if (armed) begin
        armed = 0;
        track = 1;
        edges = 0;
      end else if (track) begin
        edges++;
      end
      if (track) begin
        if (edges > 0 && prev_ov && out_ready) begin
          check_eq("ov_drop", out_valid, 0);
          check_eq("ready_back", in_ready, 1);
          track = 0;
        end else begin
          check_eq("ov_timing", out_valid, (edges >= exp_lat - 1) ? 1 : 0);
          check_eq("busy_ready", in_ready, 0);
          if (out_valid) begin
            check_eq("result", result, exp_res);
            check_eq("flags", flags, exp_flg);
            seen_res = result;
            seen_flg = flags;
          end
        end
      end else begin
        check_eq("idle_ov", out_valid, 0);
      end
      prev_ov = out_valid;
    end
  end

  task automatic run_txn(input int o, input int ia, input int ib, input int hold, input bit junk);
    int cnt;
    @(negedge clk);
    op        = o[3:0];
    a         = ia[N-1:0];
    b         = ib[N-1:0];
    in_valid  = 1'b1;
    out_ready = 1'b0;
    seen_res  = -1;
    seen_flg  = -1;
    model(o, ia, ib, exp_res, exp_flg, exp_lat);
    check_eq("accept_ready", in_ready, 1);
    armed = 1;
    @(negedge clk);
    in_valid = junk;
    if (junk) begin
      op = 4'($urandom);
      a  = N'($urandom);
      b  = N'($urandom);
    end
    cnt = 0;
    while (!out_valid && cnt < 40) begin
      @(negedge clk);
      cnt++;
    end
    check_eq("out_valid_wait", out_valid, 1);
    repeat (hold) @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int r, f, l;
    repeat (3) @(negedge clk);
    check_eq("rst_in_ready", in_ready, 1);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_result", result, 0);
    check_eq("rst_flags", flags, 0);
    rst_n = 1'b1;

    model(0, 9, 8, r, f, l);
    check_eq("model_add_res", r, 1);
    check_eq("model_add_flg", f, 5'b00011);
    model(1, 2, 3, r, f, l);
    check_eq("model_sub_flg", f, 5'b01010);
    model(3, 13, 4, r, f, l);
    check_eq("model_div_lat", l, 6);

    run_txn(0, 9, 8, 0, 0);
    check_eq("add_res", seen_res, 1);
    check_eq("add_flg", seen_flg, 5'b00011);
    run_txn(0, 7, 1, 1, 0);
    check_eq("add_ovf_flg", seen_flg, 5'b01001);
    run_txn(3, 13, 4, 0, 0);
    check_eq("div_res", seen_res, 3);
    check_eq("div_flg", seen_flg, 0);
    run_txn(4, 13, 4, 0, 0);
    check_eq("mod_res", seen_res, 1);
    run_txn(3, 7, 0, 0, 0);
    check_eq("div0_res", seen_res, 15);
    check_eq("div0_flg", seen_flg, 5'b11000);
    run_txn(4, 7, 0, 0, 0);
    check_eq("mod0_res", seen_res, 7);
    check_eq("mod0_flg", seen_flg, 5'b10000);
    run_txn(2, 5, 6, 5, 1);
    check_eq("mul_res", seen_res, 14);
    check_eq("mul_flg", seen_flg, 5'b01010);
    run_txn(9, 3, 1, 0, 0);
    check_eq("shl_res", seen_res, 6);
    run_txn(8, 8, 5, 0, 0);
    check_eq("shr_res", seen_res, 0);
    check_eq("shr_flg", seen_flg, 5'b00100);
    run_txn(1, 2, 3, 0, 0);
    check_eq("sub_res", seen_res, 15);
    check_eq("sub_flg", seen_flg, 5'b01010);
    run_txn(12, 5, 5, 0, 0);
    check_eq("ill_res", seen_res, 0);
    check_eq("ill_flg", seen_flg, 0);

    // Reset in the middle of a division.
    @(negedge clk);
    op = 4'd3; a = 4'd13; b = 4'd4; in_valid = 1'b1;
    model(3, 13, 4, exp_res, exp_flg, exp_lat);
    check_eq("div_abort_accept", in_ready, 1);
    armed = 1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("abort_out_valid", out_valid, 0);
    check_eq("abort_in_ready", in_ready, 1);
    check_eq("abort_result", result, 0);
    check_eq("abort_flags", flags, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (N + 4) begin
      @(negedge clk);
      check_eq("no_stale", out_valid, 0);
    end

    for (int i = 0; i < 150; i++) begin
      int o, ia, ib;
      o  = ($urandom % 8 == 0) ? int'($urandom_range(10, 15)) : int'($urandom_range(0, 9));
      ia = $urandom_range(0, M);
      ib = ($urandom % 5 == 0) ? 0 : int'($urandom_range(0, M));
      run_txn(o, ia, ib, $urandom_range(0, 3), 1'($urandom % 2));
    end

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
